mig_port_resp: RTL
==================

MIG_PORT_RESP -- requirements
Module: mig_port_resp

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 4096, giving the number of 128-bit memory words (power of two).
REQ-002 The module SHALL have parameter CMD_DEPTH, default 4, giving the command FIFO depth in entries.
REQ-003 The module SHALL have parameter DATA_DEPTH, default 64, giving the depth in words of each of the write FIFO and the read FIFO.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port cmd_en, input, 1: command push strobe.
REQ-007 Port cmd_instr, input, 3: instruction. 000 = write, 010 = write with precharge, 001 = read, 011 = read with precharge; all other values are no-ops.
REQ-008 Port cmd_bl, input, 6: burst length minus 1.
REQ-009 Port cmd_byte_addr, input, 30: start byte address.
REQ-010 Port cmd_empty and port cmd_full, outputs, 1 each: command FIFO status.
REQ-011 Port wr_en, input, 1: write-data push strobe.
REQ-012 Port wr_data, input, 128: write data.
REQ-013 Port wr_mask, input, 16: byte mask; a 1 bit means that byte is not written.
REQ-014 Port wr_empty and port wr_full, outputs, 1 each: write FIFO status.
REQ-015 Port wr_count, output, 7: write FIFO occupancy.
REQ-016 Port wr_underrun, output, 1: write burst is stalled for lack of data.
REQ-017 Port rd_en, input, 1: read-data pop strobe.
REQ-018 Port rd_data, output, 128: read data, first-word-fall-through.
REQ-019 Port rd_empty and port rd_full, outputs, 1 each: read FIFO status.
REQ-020 Port rd_count, output, 7: read FIFO occupancy.
REQ-021 Port rd_overflow, output, 1: sticky, set by a read FIFO push while full.
REQ-022 Port error, output, 1: sticky, set by cmd_en while cmd_full, wr_en while wr_full, or rd_en while rd_empty.

Function
REQ-023 The command FIFO SHALL capture {instr, bl, addr} on cmd_en && !cmd_full, so that cmd_empty deasserts the following cycle; a push while full SHALL be dropped.
REQ-024 The write FIFO SHALL capture {wr_data, wr_mask} on wr_en && !wr_full; a push while full SHALL be dropped.
REQ-025 rd_data SHALL present the head word whenever !rd_empty; rd_en && !rd_empty SHALL pop the head; a pop while empty SHALL have no effect on the FIFO.
REQ-026 The executor FSM SHALL have exactly the states IDLE, WRITE, READ and DRAIN.
REQ-027 In IDLE with !cmd_empty, the FSM SHALL pop one command and load word pointer = cmd_byte_addr[4+log2(MEM_WORDS)-1:4] and beats = cmd_bl+1 (range 1..64).
REQ-028 Next state from IDLE SHALL be WRITE for 000/010, READ for 001/011, and IDLE for a no-op, which consumes one cycle.
REQ-029 cmd_byte_addr bits [3:0] and all bits above the memory range SHALL be ignored.
REQ-030 The word pointer SHALL increment per beat and wrap modulo MEM_WORDS.
REQ-031 In WRITE, each cycle with !wr_empty SHALL pop one word and write the unmasked bytes at the pointer.
REQ-032 In WRITE with wr_empty, wr_underrun SHALL be 1 and the FSM SHALL stall with no memory write.
REQ-033 WRITE SHALL go to IDLE after the last beat.
REQ-034 In READ, the FSM SHALL issue one synchronous memory read per cycle only while rd_count + in-flight reads < DATA_DEPTH, and SHALL stall otherwise; the read data SHALL be pushed into the read FIFO one cycle after issue.
REQ-035 After the last read issue, READ SHALL go to DRAIN for one cycle to complete the final push, then to IDLE.
REQ-036 Commands SHALL execute strictly in order, so a read following a write to the same address returns the new data.
REQ-037 Latency SHALL be: with the FSM idle and the FIFOs empty, a read cmd_en sampled at cycle N SHALL give rd_empty = 0 at cycle N+4.
REQ-038 Simultaneous push and pop on any FIFO SHALL leave its count unchanged; the count SHALL never exceed its depth.
REQ-039 rd_overflow SHALL remain 0 in any correct operation, because reads are flow-controlled.

Reset
REQ-040 On rst_n low, the SHALL be asynchronously: FSM in IDLE, all FIFO pointers and counts 0, cmd_empty = wr_empty = rd_empty = 1, all full flags 0, wr_underrun = rd_overflow = error = 0.
REQ-041 Reset SHALL abort any burst in progress, discard all queued commands and data, and leave memory contents unchanged.

Verification
REQ-042 Write then read: push 8 words 0x..01 to 0x..08, write bl = 7 at 0x100, read bl = 7 at 0x100 -> the same 8 words in order; first word visible 4 cycles after the read cmd_en.
REQ-043 Byte mask: write 0xFF..FF, then overwrite with mask 0xFFFE and data 0 -> readback = 0xFF..FF00.
REQ-044 Wrap: write bl = 3 at byte address (MEM_WORDS-2)*16 -> words land at MEM_WORDS-2, MEM_WORDS-1, 0, 1.
REQ-045 Underrun: issue write bl = 7 with only 3 words queued -> wr_underrun = 1 until 5 more words arrive, and the burst then completes correctly.
REQ-046 Backpressure: hold rd_en = 0, read bl = 63 twice -> rd_count saturates at 64, rd_overflow stays 0, and all 128 words are correct after draining.
REQ-047 Reset mid-burst: assert rst_n low during the 4th beat of a read -> all flags return to reset values immediately, and a subsequent command executes normally.

Source files
------------

// File: rtl/mig_port_resp.sv
// rtl/mig_port_resp.sv - single-port memory controller model with command, write and read FIFOs
// Commands execute in order against a byte-maskable 128-bit memory; reads are flow-controlled into the read FIFO.

module mig_port_resp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt_q;
    assign dout    = store_q[rp_q];

    // Storage is not reset: clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (do_push) store_q[wp_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
            if (do_pop)  rp_q <= (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end
endmodule

module mig_port_resp #(
    parameter int MEM_WORDS  = 4096,
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_en,
    input  logic [2:0]   cmd_instr,
    input  logic [5:0]   cmd_bl,
    input  logic [29:0]  cmd_byte_addr,
    output logic         cmd_empty,
    output logic         cmd_full,
    input  logic         wr_en,
    input  logic [127:0] wr_data,
    input  logic [15:0]  wr_mask,
    output logic         wr_empty,
    output logic         wr_full,
    output logic [6:0]   wr_count,
    output logic         wr_underrun,
    input  logic         rd_en,
    output logic [127:0] rd_data,
    output logic         rd_empty,
    output logic         rd_full,
    output logic [6:0]   rd_count,
    output logic         rd_overflow,
    output logic         error
);
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CMD_W = 3 + 6 + AW;
    localparam int DCW   = $clog2(DATA_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [6:0]      beats_q, beats_d;
    logic            rvalid_q, rd_overflow_q, error_q;
    logic [127:0]    mem_rdata_q;
    logic [127:0]    mem_q [MEM_WORDS];

    logic [CMD_W-1:0] cmd_head;
    logic [2:0]       head_instr;
    logic [5:0]       head_bl;
    logic [AW-1:0]    head_ptr;
    logic [143:0]     wr_head;
    logic [DCW-1:0]   wr_cnt, rd_cnt;
    logic             cmd_pop, wr_pop, mem_we, rd_issue, rd_room;
    logic             unused_bits;

    // Only the word-address bits are queued; the byte offset and out-of-range bits are dropped here.
    mig_port_resp_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(cmd_en), .din({cmd_instr, cmd_bl, cmd_byte_addr[4+AW-1:4]}),
        .pop(cmd_pop), .dout(cmd_head),
        .empty(cmd_empty), .full(cmd_full), .count()
    );

    mig_port_resp_fifo #(.W(144), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(wr_en), .din({wr_data, wr_mask}),
        .pop(wr_pop), .dout(wr_head),
        .empty(wr_empty), .full(wr_full), .count(wr_cnt)
    );

    mig_port_resp_fifo #(.W(128), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(rvalid_q), .din(mem_rdata_q),
        .pop(rd_en), .dout(rd_data),
        .empty(rd_empty), .full(rd_full), .count(rd_cnt)
    );

    assign head_instr  = cmd_head[AW+6 +: 3];
    assign head_bl     = cmd_head[AW +: 6];
    assign head_ptr    = cmd_head[AW-1:0];
    assign unused_bits = ^{cmd_byte_addr[3:0], cmd_byte_addr[29:4+AW], head_instr[1]};

    assign wr_count    = 7'(wr_cnt);
    assign rd_count    = 7'(rd_cnt);
    assign wr_underrun = (state_q == WRITE) && wr_empty;
    assign rd_overflow = rd_overflow_q;
    assign error       = error_q;

    // An issued read still in flight already owns a read FIFO slot.
    assign rd_room = (8'(rd_cnt) + {7'd0, rvalid_q}) < 8'(DATA_DEPTH);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        beats_d  = beats_q;
        cmd_pop  = 1'b0;
        wr_pop   = 1'b0;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    ptr_d   = head_ptr;
                    beats_d = 7'(head_bl) + 7'd1;
                    if (!head_instr[2]) state_d = head_instr[0] ? READ : WRITE;
                end
            end
            WRITE: begin
                if (!wr_empty) begin
                    wr_pop  = 1'b1;
                    mem_we  = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    beats_d = beats_q - 7'd1;
                    if (beats_q == 7'd1) state_d = IDLE;
                end
            end
            READ: begin
                if (rd_room) begin
                    rd_issue = 1'b1;
                    ptr_d    = ptr_q + AW'(1);
                    beats_d  = beats_q - 7'd1;
                    if (beats_q == 7'd1) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            beats_q       <= '0;
            rvalid_q      <= 1'b0;
            rd_overflow_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            beats_q       <= beats_d;
            rvalid_q      <= rd_issue;
            rd_overflow_q <= rd_overflow_q | (rvalid_q && rd_full);
            error_q       <= error_q | (cmd_en && cmd_full) | (wr_en && wr_full) | (rd_en && rd_empty);
        end
    end

    // Memory contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (!wr_head[b]) mem_q[ptr_q][8*b +: 8] <= wr_head[16 + 8*b +: 8];
            end
        end
        if (rd_issue) mem_rdata_q <= mem_q[ptr_q];
    end
endmodule
